nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 8 +
 rtl/cra4bits.sv | 21 ++
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the serial adders: slice width and FSM state encoding.
package nibble_serial_adder_pkg;
    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/cra4bits.sv
// 4-bit carry-ripple adder slice.
module cra4bits
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice per RUN cycle, valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [1:0]       dbg_state_o
);
    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // the producer holds its data stable until that edge.

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;

    logic [IDX_W+1:0]   base;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_cout;

    // Bit offset of the current slice (idx * 4).
    assign base    = {idx_q, 2'b00};
    assign slice_a = a_q[base +: SLICE_W];
    assign slice_b = b_q[base +: SLICE_W];

    cra4bits u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[base +: SLICE_W] = slice_s;
                carry_d              = slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign s           = s_q;
    assign cout        = carry_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed vectors plus random stalls.
module tb_nibble_serial_adder;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic [1:0]   dbg_state;

    logic [W:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_cyc   = 0;
    bit rnd_ready = 1'b0;
    bit held      = 1'b0;
    logic [W:0] held_val;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .s           (s),
        .cout        (cout),
        .dbg_state_o (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // random consumer backpressure
    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: latency, stability under stall, result vs expected queue
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            if (held) begin
                check("stall_stable", {cout, s}, held_val);
            end else begin
                check("latency", (W+1)'(cyc - hs_cyc), (W+1)'(NIB));
            end
            if (out_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got %h expected none", {cout, s});
                end else begin
                    check("result", {cout, s}, exp_q.pop_front());
                end
            end else begin
                held     = 1'b1;
                held_val = {cout, s};
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input bit push);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back({1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc});
        #1;
        in_valid = 1'b0;
        hs_cyc   = cyc;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d expected 0 pending", exp_q.size());
        end
    endtask

    task automatic check_idle_reset(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, (W+1)'(in_ready), (W+1)'(1));
        check({tag, "_out_valid"}, (W+1)'(out_valid), (W+1)'(0));
        check({tag, "_s_cout"}, {cout, s}, '0);
        check({tag, "_state"}, (W+1)'(dbg_state), (W+1)'(0));
    endtask

    initial begin
        int guard;
        bit seen_valid;

        // reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_reset("reset");

        // wrap-around and carry-in
        @(posedge clk); #1;
        do_op(16'hFFFF, 16'h0001, 1'b0, 1);
        do_op(16'h1234, 16'h4321, 1'b1, 1);
        do_op(16'h0000, 16'h0000, 1'b0, 1);
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1);
        drain();

        // busy input ignored during RUN
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1);
        check("busy_in_ready", (W+1)'(in_ready), (W+1)'(0));
        a = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // backpressure: three stalled cycles in DONE
        out_ready = 1'b0;
        do_op(16'h8000, 16'h8000, 1'b0, 1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_reach_done", (W+1)'(out_valid), (W+1)'(1));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check("bp_idle_state", (W+1)'(dbg_state), (W+1)'(0));
        check("bp_consumed", (W+1)'(exp_q.size()), '0);

        // reset in the 2nd RUN cycle discards the operation
        do_op(16'h0005, 16'h0003, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_reset("midrst");
        seen_valid = 1'b0;
        repeat (NIB + 3) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_valid", (W+1)'(seen_valid), (W+1)'(0));
        @(posedge clk); #1;
        do_op(16'h0001, 16'h0001, 1'b0, 1);
        drain();

        // random operands with random stalls
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                  1'($urandom_range(0, 1)), 1);
        end
        drain();
        rnd_ready = 1'b0;
        check("queue_empty", (W+1)'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
